// File: rtl/bus_arbiter_rr_if.sv
// Bus arbitration signal bundle: master requests and slave readiness in,
// grants and bus status out.
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3
);
  localparam int MSEL_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_SLAVES-1:0]  sready;
  logic                   err_clr;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [MSEL_W-1:0]      msel;
  logic                   bus_busy;
  logic                   preempt;
  logic                   timeout_err;

  // arbiter side
  modport master (
    input  breq, sready, err_clr,
    output bgrant, msel, bus_busy, preempt, timeout_err
  );

  // requester / bus side
  modport slave (
    output breq, sready, err_clr,
    input  bgrant, msel, bus_busy, preempt, timeout_err
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with bounded tenure (preemption) and a watchdog on
// slave readiness after each release.
//
//   state        | meaning
//   S_IDLE       | bus free, no owner
//   S_GRANT      | owner holds bgrant, tenure counted
//   S_WAIT_READY | grant dropped, waiting for all sready (watchdog running)
module bus_arbiter_rr #(
  parameter int NUM_MASTERS   = 2,
  parameter int NUM_SLAVES    = 3,
  parameter int MAX_HOLD      = 16,
  parameter int READY_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  bus_arbiter_rr_if.master  bif
);
  localparam int MSEL_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int WAIT_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT + 1) : 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT      = 2'd1,
    S_WAIT_READY = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [MSEL_W-1:0]      r_owner;
  logic [MSEL_W-1:0]      r_last;
  logic [HOLD_W-1:0]      r_hold;
  logic [WAIT_W-1:0]      r_wait;
  logic                   r_preempt;
  logic                   r_timeout_err;

  logic [MSEL_W-1:0]      w_win;
  logic                   w_found;
  logic [NUM_MASTERS-1:0] w_owner_mask;
  logic                   w_others;
  logic                   w_all_ready;
  logic                   w_hold_hit;
  logic                   w_arb_load;
  logic                   w_preempt_nxt;
  logic                   w_timeout_set;

  assign w_owner_mask = NUM_MASTERS'(1) << r_owner;
  assign w_others     = |(bif.breq & ~w_owner_mask);
  assign w_all_ready  = &bif.sready;
  // >= so a requester arriving after the counter saturates still preempts
  assign w_hold_hit   = (MAX_HOLD != 0) && (r_hold >= HOLD_LAST);

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!w_found && bif.breq[(int'(r_last) + k) % NUM_MASTERS]) begin
        w_found = 1'b1;
        w_win   = MSEL_W'((int'(r_last) + k) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_arb_load    = 1'b0;
    w_preempt_nxt = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_arb_load  = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!bif.breq[r_owner]) begin
          w_state_nxt = S_WAIT_READY;
        end else if (w_hold_hit && w_others) begin
          w_state_nxt   = S_WAIT_READY;
          w_preempt_nxt = 1'b1;
        end
      end
      S_WAIT_READY: begin
        if (w_all_ready) begin
          if (w_found) begin
            w_arb_load  = 1'b1;
            w_state_nxt = S_GRANT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_owner       <= '0;
      r_last        <= MSEL_W'(NUM_MASTERS - 1);
      r_hold        <= '0;
      r_wait        <= '0;
      r_preempt     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_preempt <= w_preempt_nxt;
      if (w_arb_load) begin
        r_owner <= w_win;
        r_last  <= w_win;
      end
      if (r_state == S_GRANT && w_state_nxt == S_GRANT) begin
        if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
      end
      if (r_state == S_WAIT_READY && w_state_nxt == S_WAIT_READY) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (w_timeout_set) begin
        r_timeout_err <= 1'b1;
      end else if (bif.err_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign bif.bgrant      = (r_state == S_GRANT) ? w_owner_mask : '0;
  assign bif.msel        = r_owner;
  assign bif.bus_busy    = (r_state != S_IDLE);
  assign bif.preempt     = r_preempt;
  assign bif.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a cycle-level behavioural model is checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_bus_arbiter_rr;
  localparam int NM = 2;
  localparam int NS = 3;
  localparam int MH = 16;
  localparam int RT = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bif ();

  bus_arbiter_rr #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .MAX_HOLD(MH), .READY_TIMEOUT(RT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bif  (bif.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 = bus free, 1 = owned, 2 = draining after release
  int m_phase = 0, m_owner = 0, m_last = NM - 1, m_tenure = 0, m_drain = 0;
  bit m_pre = 0, m_err = 0;

  function automatic int pick(input int last, input logic [NM-1:0] req);
    for (int k = 1; k <= NM; k++) begin
      if (req[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  initial begin
    int w;
    bit to;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_phase = 0; m_owner = 0; m_last = NM - 1; m_tenure = 0; m_drain = 0;
        m_pre = 0; m_err = 0;
      end else begin
        to = 0;
        m_pre = 0;
        case (m_phase)
          0: begin
            w = pick(m_last, bif.breq);
            if (w >= 0) begin m_owner = w; m_last = w; m_phase = 1; m_tenure = 1; end
          end
          1: begin
            if (!bif.breq[m_owner]) begin
              m_phase = 2; m_drain = 1;
            end else if (MH > 0 && m_tenure >= MH && (bif.breq & ~(NM'(1) << m_owner)) != 0) begin
              m_phase = 2; m_drain = 1; m_pre = 1;
            end else begin
              m_tenure++;
            end
          end
          default: begin
            if (&bif.sready) begin
              w = pick(m_last, bif.breq);
              if (w >= 0) begin m_owner = w; m_last = w; m_phase = 1; m_tenure = 1; end
              else m_phase = 0;
            end else if (m_drain >= RT) begin
              to = 1; m_phase = 0;
            end else begin
              m_drain++;
            end
          end
        endcase
        if (to) m_err = 1;
        else if (bif.err_clr) m_err = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        check("mdl_bgrant", bif.bgrant, (m_phase == 1) ? (1 << m_owner) : 0);
        check("mdl_msel", bif.msel, m_owner);
        check("mdl_busy", bif.bus_busy, (m_phase != 0) ? 1 : 0);
        check("mdl_preempt", bif.preempt, m_pre);
        check("mdl_timeout_err", bif.timeout_err, m_err);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bif.breq = '0; bif.err_clr = 1'b0; bif.sready = '1;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic wait_grant(output logic [NM-1:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.bgrant != '0) begin
        g = bif.bgrant;
        break;
      end
    end
    if (g == '0) begin
      n_checks++; n_fail++;
      $display("FAIL wait_grant: no grant within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NM-1:0] gr;
    bit saw_pre;
    bif.breq = '0; bif.sready = '1; bif.err_clr = 1'b0;

    // single request and reset values
    @(negedge clk);
    check("rst_bgrant", bif.bgrant, 0);
    check("rst_msel", bif.msel, 0);
    check("rst_busy", bif.bus_busy, 0);
    check("rst_err", bif.timeout_err, 0);
    rstn = 1'b1;
    bif.breq = 2'b01;
    tick(1);
    check("single_grant", bif.bgrant, 1);
    check("single_msel", bif.msel, 0);
    tick(3);
    bif.breq = 2'b00;
    tick(1);
    check("single_release", bif.bgrant, 0);
    check("single_busy_wait", bif.bus_busy, 1);
    tick(1);
    check("single_idle", bif.bus_busy, 0);

    // round-robin fairness
    do_reset();
    bif.breq = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_grant(gr);
      check("rr_grant", gr, (g % 2) ? 2 : 1);
      check("rr_msel", bif.msel, g % 2);
      tick(2);
      check("rr_hold", bif.bgrant, gr);
      bif.breq = bif.breq & ~gr;
      tick(1);
      check("rr_gap", bif.bgrant, 0);
      bif.breq = 2'b11;
    end

    // preemption after MAX_HOLD grant cycles
    do_reset();
    bif.breq = 2'b01;
    tick(1);
    check("pre_first", bif.bgrant, 1);
    tick(1);
    bif.breq = 2'b11;
    tick(14);
    check("pre_cycle16", bif.bgrant, 1);
    check("pre_cycle16_nopulse", bif.preempt, 0);
    tick(1);
    check("pre_revoked", bif.bgrant, 0);
    check("pre_pulse", bif.preempt, 1);
    tick(1);
    check("pre_pulse_end", bif.preempt, 0);
    check("pre_next_grant", bif.bgrant, 2);

    // no other requester: indefinite tenure
    do_reset();
    bif.breq = 2'b01;
    saw_pre = 0;
    for (int i = 0; i < 120; i++) begin
      tick(1);
      if (bif.preempt) saw_pre = 1;
    end
    check("solo_still_granted", bif.bgrant, 1);
    check("solo_no_preempt", saw_pre, 0);

    // slave not ready after release
    do_reset();
    bif.breq = 2'b01;
    tick(1);
    bif.breq = 2'b11;
    tick(2);
    bif.breq = 2'b10;
    bif.sready = 3'b101;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("nrdy_no_grant", bif.bgrant, 0);
      check("nrdy_busy", bif.bus_busy, 1);
    end
    bif.sready = 3'b111;
    tick(1);
    check("nrdy_grant_m1", bif.bgrant, 2);
    check("nrdy_msel", bif.msel, 1);

    // ready timeout, clear, and set-wins-over-clear
    do_reset();
    bif.breq = 2'b01;
    tick(1);
    bif.breq = 2'b00;
    bif.sready = 3'b011;
    tick(64);
    check("to_busy_last", bif.bus_busy, 1);
    check("to_err_before", bif.timeout_err, 0);
    tick(1);
    check("to_err_set", bif.timeout_err, 1);
    check("to_idle", bif.bus_busy, 0);
    bif.err_clr = 1'b1;
    tick(1);
    check("to_err_cleared", bif.timeout_err, 0);
    bif.err_clr = 1'b0;
    bif.breq = 2'b01;
    tick(1);
    check("to2_grant", bif.bgrant, 1);
    bif.breq = 2'b00;
    bif.err_clr = 1'b1;
    tick(64);
    check("to2_err_before", bif.timeout_err, 0);
    tick(1);
    check("to2_set_wins", bif.timeout_err, 1);
    bif.err_clr = 1'b0;
    tick(1);
    check("to2_sticky", bif.timeout_err, 1);

    // asynchronous reset mid-grant
    bif.breq = 2'b10;
    tick(1);
    check("ar_grant_m1", bif.bgrant, 2);
    check("ar_msel_m1", bif.msel, 1);
    check("ar_err_pre", bif.timeout_err, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_bgrant", bif.bgrant, 0);
    check("ar_msel", bif.msel, 0);
    check("ar_err", bif.timeout_err, 0);
    check("ar_busy", bif.bus_busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    bif.breq = 2'b11;
    bif.sready = 3'b111;
    tick(1);
    check("ar_first_m0", bif.bgrant, 1);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
